video_timing_gen: RTL and testbench

- Display timing generator: the source end of the pixel-coordinate interface that all sprite and background renderers consume.
- Derives a pixel-rate enable from the system clock and runs horizontal and vertical counters.
- Drives pix_row/pix_col, video_on, horiz_sync and vert_sync to the VGA pins, plus frame/line strobes for game-logic updates.
- Default timing: 640x480@60 (800x525 total) from a 100 MHz clk with divide-by-4.

---
 rtl/video_timing_gen.sv | 94 +++++++++
 tb/tb_video_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Display timing generator: pixel-rate enable, h/v counters and registered
// sync/blank/tick decodes that are always aligned with pix_row/pix_col.
module video_timing_gen #(
  parameter int   CLK_DIV     = 4,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [9:0]  pix_col,
  output logic [9:0]  pix_row,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so zero-width windows and edge cases never wrap.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LIM = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LIM = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             adv, line_wrap, frame_wrap;
  logic [9:0]       col_nx, row_nx;
  logic             von_nx, hs_nx, vs_nx;

  always_comb begin
    adv        = (div == DIV_LAST);
    line_wrap  = adv && (pix_col == H_LAST);
    frame_wrap = line_wrap && (pix_row == V_LAST);
    col_nx     = pix_col;
    row_nx     = pix_row;
    if (adv) begin
      if (line_wrap) begin
        col_nx = '0;
        row_nx = frame_wrap ? '0 : pix_row + 10'd1;
      end else begin
        col_nx = pix_col + 10'd1;
      end
    end
    // Decode the values the counters are about to take so outputs stay coherent.
    von_nx = ({1'b0, col_nx} < H_ACT) && ({1'b0, row_nx} < V_ACT);
    hs_nx  = (({1'b0, col_nx} >= HS_BEG) && ({1'b0, col_nx} < HS_LIM)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nx  = (({1'b0, row_nx} >= VS_BEG) && ({1'b0, row_nx} < VS_LIM)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      pix_col     <= H_LAST;
      pix_row     <= V_LAST;
      video_on    <= 1'b0;
      horiz_sync  <= ~SYNC_ACTIVE;
      vert_sync   <= ~SYNC_ACTIVE;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      div         <= adv ? '0 : div + 1'b1;
      pix_en      <= adv;
      pix_col     <= col_nx;
      pix_row     <= row_nx;
      video_on    <= von_nx;
      horiz_sync  <= hs_nx;
      vert_sync   <= vs_nx;
      line_tick   <= line_wrap;
      frame_tick  <= frame_wrap;
      frame_count <= frame_count + 16'(frame_wrap);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default, tiny and degenerate-timing instances
// on one clock, directed vector table plus reset and wrap sequences.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n, rst_w_n;
  always #5 clk = ~clk;

  logic d_pe, d_von, d_hs, d_vs, d_lt, d_ft;
  logic [9:0] d_col, d_row;
  logic [15:0] d_fc;
  logic t_pe, t_von, t_hs, t_vs, t_lt, t_ft;
  logic [9:0] t_col, t_row;
  logic [15:0] t_fc;
  logic w_pe, w_von, w_hs, w_vs, w_lt, w_ft;
  logic [9:0] w_col, w_row;
  logic [15:0] w_fc;

  video_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .pix_en(d_pe), .pix_col(d_col), .pix_row(d_row),
    .video_on(d_von), .horiz_sync(d_hs), .vert_sync(d_vs), .line_tick(d_lt),
    .frame_tick(d_ft), .frame_count(d_fc));

  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE(1'b1)
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .pix_en(t_pe), .pix_col(t_col), .pix_row(t_row),
    .video_on(t_von), .horiz_sync(t_hs), .vert_sync(t_vs), .line_tick(t_lt),
    .frame_tick(t_ft), .frame_count(t_fc));

  // 1x1 raster with no porches/sync: a frame every clk, so frame_count wraps quickly.
  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
  ) dut_w (
    .clk(clk), .rst_n(rst_w_n), .pix_en(w_pe), .pix_col(w_col), .pix_row(w_row),
    .video_on(w_von), .horiz_sync(w_hs), .vert_sync(w_vs), .line_tick(w_lt),
    .frame_tick(w_ft), .frame_count(w_fc));

  int checks = 0;
  int errors = 0;
  int wcnt;

  always @(posedge clk) begin
    if (!rst_w_n) wcnt <= 0;
    else          wcnt <= wcnt + 1;
  end

  typedef struct {
    int inst; int k;
    int pe; int col; int row; int von; int hs; int vs; int lt; int ft; int fc;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int inst, int k, int pe, int col, int row, int von,
                              int hs, int vs, int lt, int ft, int fc);
    vec_t v;
    v.inst = inst; v.k = k; v.pe = pe; v.col = col; v.row = row; v.von = von;
    v.hs = hs; v.vs = vs; v.lt = lt; v.ft = ft; v.fc = fc;
    return v;
  endfunction

  task automatic check_vec(input vec_t v);
    string p;
    p = $sformatf("i%0d_k%0d_", v.inst, v.k);
    if (v.inst == 0) begin
      chk({p, "pix_en"}, d_pe, v.pe);      chk({p, "pix_col"}, d_col, v.col);
      chk({p, "pix_row"}, d_row, v.row);   chk({p, "video_on"}, d_von, v.von);
      chk({p, "hsync"}, d_hs, v.hs);       chk({p, "vsync"}, d_vs, v.vs);
      chk({p, "line_tick"}, d_lt, v.lt);   chk({p, "frame_tick"}, d_ft, v.ft);
      chk({p, "frame_count"}, d_fc, v.fc);
    end else begin
      chk({p, "pix_en"}, t_pe, v.pe);      chk({p, "pix_col"}, t_col, v.col);
      chk({p, "pix_row"}, t_row, v.row);   chk({p, "video_on"}, t_von, v.von);
      chk({p, "hsync"}, t_hs, v.hs);       chk({p, "vsync"}, t_vs, v.vs);
      chk({p, "line_tick"}, t_lt, v.lt);   chk({p, "frame_tick"}, t_ft, v.ft);
      chk({p, "frame_count"}, t_fc, v.fc);
    end
  endtask

  task automatic chk_default_reset(input string nm);
    chk({nm, "_pix_en"}, d_pe, 0);    chk({nm, "_pix_col"}, d_col, 799);
    chk({nm, "_pix_row"}, d_row, 524); chk({nm, "_video_on"}, d_von, 0);
    chk({nm, "_hsync"}, d_hs, 1);     chk({nm, "_vsync"}, d_vs, 1);
    chk({nm, "_line_tick"}, d_lt, 0); chk({nm, "_frame_tick"}, d_ft, 0);
    chk({nm, "_frame_count"}, d_fc, 0);
  endtask

  initial begin
    int kcur, n, m, vs_cnt, hs_cnt;
    //        inst k     pe col row von hs vs lt ft fc
    vt.push_back(mk(0, 0,    0, 799, 524, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(1, 0,    0, 11,  6,   0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1,    1, 0,   0,   1, 0, 0, 1, 1, 1));
    vt.push_back(mk(1, 2,    1, 1,   0,   1, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 3,    0, 799, 524, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(0, 4,    1, 0,   0,   1, 1, 1, 1, 1, 1));
    vt.push_back(mk(0, 5,    0, 0,   0,   1, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 7,    0, 0,   0,   1, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 8,    1, 1,   0,   1, 1, 1, 0, 0, 1));
    vt.push_back(mk(1, 8,    1, 7,   0,   1, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 9,    1, 8,   0,   0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 10,   1, 9,   0,   0, 1, 0, 0, 0, 1));
    vt.push_back(mk(1, 11,   1, 10,  0,   0, 1, 0, 0, 0, 1));
    vt.push_back(mk(1, 12,   1, 11,  0,   0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 13,   1, 0,   1,   1, 0, 0, 1, 0, 1));
    vt.push_back(mk(1, 49,   1, 0,   4,   0, 0, 0, 1, 0, 1));
    vt.push_back(mk(1, 61,   1, 0,   5,   0, 0, 1, 1, 0, 1));
    vt.push_back(mk(1, 72,   1, 11,  5,   0, 0, 1, 0, 0, 1));
    vt.push_back(mk(1, 73,   1, 0,   6,   0, 0, 0, 1, 0, 1));
    vt.push_back(mk(1, 84,   1, 11,  6,   0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 85,   1, 0,   0,   1, 0, 0, 1, 1, 2));
    vt.push_back(mk(1, 169,  1, 0,   0,   1, 0, 0, 1, 1, 3));
    vt.push_back(mk(0, 2560, 1, 639, 0,   1, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 2564, 1, 640, 0,   0, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 2624, 1, 655, 0,   0, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 2628, 1, 656, 0,   0, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 3008, 1, 751, 0,   0, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 3012, 1, 752, 0,   0, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 3200, 1, 799, 0,   0, 1, 1, 0, 0, 1));
    vt.push_back(mk(0, 3204, 1, 0,   1,   1, 1, 1, 1, 0, 1));
    vt.push_back(mk(0, 3205, 0, 0,   1,   1, 1, 1, 0, 0, 1));

    rst_n = 1'b0;
    rst_w_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_w_n = 1'b1;
    kcur = 0;

    foreach (vt[i]) begin
      if (vt[i].k < kcur) chk($sformatf("table_order_%0d", i), vt[i].k, kcur);
      while (kcur < vt[i].k) begin
        @(posedge clk);
        kcur++;
      end
      #1;
      check_vec(vt[i]);
    end

    // Tiny raster: frame period and sync duty over one full frame.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!t_ft && n < 200);
    chk("tiny_ft_found", int'(t_ft), 1);
    m = 0; vs_cnt = 0; hs_cnt = 0;
    do begin
      vs_cnt += int'(t_vs);
      hs_cnt += int'(t_hs);
      @(posedge clk); #1; m++;
    end while (!t_ft && m < 200);
    chk("tiny_ft_period", m, 84);
    chk("tiny_vs_clks", vs_cnt, 12);
    chk("tiny_hs_clks", hs_cnt, 14);

    // Async reset mid-line on the default raster.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (d_col != 10'd300 && n < 4000);
    chk("wait_col300", d_col, 300);
    #2;
    rst_n = 1'b0;
    #1;
    chk_default_reset("async_rst");
    chk("async_rst_tiny_hsync", t_hs, 0);
    chk("async_rst_tiny_col", t_col, 11);
    repeat (2) @(posedge clk);
    #1;
    chk_default_reset("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        chk($sformatf("restart_k%0d_pix_en", k), d_pe, 0);
        chk($sformatf("restart_k%0d_pix_col", k), d_col, 799);
        chk($sformatf("restart_k%0d_frame_tick", k), d_ft, 0);
      end else begin
        check_vec(mk(0, 4, 1, 0, 0, 1, 1, 1, 1, 1, 1));
      end
    end

    // frame_count wrap on the 1x1 raster: edge k leaves frame_count = k mod 2^16.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (wcnt < 65535 && n < 70000);
    chk("wrap_edge", wcnt, 65535);
    chk("wrap_pre_fc", w_fc, 65535);
    @(posedge clk); #1;
    chk("wrap_fc", w_fc, 0);
    chk("wrap_ft", w_ft, 1);
    chk("wrap_lt", w_lt, 1);
    chk("wrap_von", w_von, 1);
    chk("wrap_pe", w_pe, 1);
    chk("wrap_hs", w_hs, 1);
    chk("wrap_vs", w_vs, 1);
    chk("wrap_col", w_col, 0);
    chk("wrap_row", w_row, 0);
    @(posedge clk); #1;
    chk("wrap_post_fc", w_fc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
